ftdi_tx_scheduler: RTL and testbench
====================================

FTDI_TX_SCHEDULER -- requirements
Module: ftdi_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of TX requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant before forced re-arbitration (1..255).
REQ-003 SHALL have parameter GAP_CYCLES, default 12, post-handshake cycles that launched data is held stable before the next launch (1..255).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, handshake watchdog limit (used only under REQ-028).
REQ-005 SHALL have ports: in_clk  in  1  single clock; reset is asynchronous and active-low: in_rst_n  in  1.
REQ-006 SHALL have ports: in_req_valid  in  NUM_REQ  per-requester byte valid; in_req_data  in  8*NUM_REQ  bytes, requester i at bits [8i+7:8i]; in_req_last  in  NUM_REQ  byte ends packet.
REQ-007 SHALL have port out_req_ack  out  NUM_REQ  one-cycle byte-accepted pulse.
REQ-008 SHALL have ports: out_ftdi_tx_data_rdy  out  1; in_ftdi_tx_me_rdy  in  1; out_ftdi_data  out  8 (FTDI controller TX interlock).
REQ-009 SHALL have ports: in_rx_enable  in  1  system RX enable; out_ftdi_rx_ena  out  1  RX enable to FTDI controller; out_busy  out  1; out_timeout  out  1.

Function
REQ-010 SHALL implement states IDLE, LAUNCH, HANDSHAKE, RELEASE, GAP.
REQ-011 IDLE: if unlocked, SHALL round-robin among asserted in_req_valid starting from last grant+1 (first search after reset starts at index 0); if locked, SHALL consider only the locked requester.
REQ-012 IDLE -> LAUNCH when a requester is selected; the byte and its last flag SHALL be registered into out_ftdi_data on that edge.
REQ-013 LAUNCH: SHALL assert out_ftdi_tx_data_rdy and go to HANDSHAKE next cycle; data_rdy SHALL stay high throughout HANDSHAKE.
REQ-014 HANDSHAKE -> RELEASE on first cycle in_ftdi_tx_me_rdy sampled high; out_ftdi_tx_data_rdy SHALL deassert on that edge, and out_req_ack[grant] SHALL pulse exactly one cycle.
REQ-015 RELEASE -> GAP when in_ftdi_tx_me_rdy sampled low.
REQ-016 GAP: SHALL count GAP_CYCLES cycles, holding out_ftdi_data unchanged, then go to IDLE.
REQ-017 Lock SHALL be set on first byte of a grant, and cleared at the ack of a byte with last=1 or of the MAX_BURST-th byte of the grant.
REQ-018 Burst counter SHALL be 8 bits, reset to 0 at each new grant, and never wrap (clears with lock at MAX_BURST).
REQ-019 A locked requester dropping valid SHALL keep the lock; the scheduler waits in IDLE.
REQ-020 out_ftdi_rx_ena SHALL equal in_rx_enable AND NOT (state in LAUNCH or HANDSHAKE).
REQ-021 out_busy SHALL be high in any state other than IDLE, or while locked.
REQ-022 Requester data SHALL be sampled only in IDLE; changes elsewhere have no effect.

Reset
REQ-023 in_rst_n low SHALL immediately force: state IDLE, out_ftdi_tx_data_rdy 0, out_ftdi_data 0x00, out_req_ack 0, out_busy 0, out_timeout 0, lock cleared, burst counter 0, RR pointer to index NUM_REQ-1 (so index 0 is searched first).
REQ-024 Reset mid-handshake SHALL drop the byte without ack; no pending state SHALL survive.
REQ-025 out_ftdi_rx_ena SHALL follow REQ-020 combinationally, so it is in_rx_enable during reset.

Configuration
REQ-026 Macro FTDI_TX_SCHED_TIMEOUT_EN SHALL select the watchdog.
REQ-027 Without the macro: HANDSHAKE waits indefinitely, and out_timeout SHALL be tied 0.
REQ-028 With the macro: if HANDSHAKE lasts TIMEOUT_CYCLES cycles, data_rdy SHALL drop, the lock SHALL clear, out_timeout SHALL pulse one cycle, no ack SHALL be issued, and the next state SHALL be GAP.

Structure
REQ-029 Package ftdi_tx_sched_pkg SHALL hold the state encoding (3 bits) and parameter defaults.
REQ-030 Sub-module ftdi_rr_arbiter (NUM_REQ, one-hot grant, pointer update on enable) SHALL implement REQ-011.

Verification
REQ-031 Requesters 0 and 2 valid, single-byte packets 0xA5/0x3C, me_rdy 2 cycles after data_rdy -> data order 0xA5 then 0x3C, one ack each, at least GAP_CYCLES between launches.
REQ-032 Requester 1 sends a 3-byte packet while requester 3 is valid -> all 3 bytes of requester 1 before any of requester 3.
REQ-033 MAX_BURST=4, requester 0 sends a 10-byte packet, requester 1 valid -> 4 bytes from 0, then 1 byte from 1, then resumes 0.
REQ-034 Async reset asserted in HANDSHAKE -> data_rdy 0 and data 0x00 the same cycle, no ack; after release, requester 0 is served first.
REQ-035 Macro defined, TIMEOUT_CYCLES=16, me_rdy held low -> data_rdy drops after 16 cycles, single out_timeout pulse, no ack, other requesters served next.
REQ-036 in_rx_enable=1 during a transfer -> out_ftdi_rx_ena low exactly during LAUNCH/HANDSHAKE.

Source files
------------

// File: rtl/ftdi_tx_sched_pkg.sv
// Shared state encoding and parameter defaults for the FTDI TX scheduler.
package ftdi_tx_sched_pkg;

  localparam int unsigned NumReqDefault        = 4;
  localparam int unsigned MaxBurstDefault      = 16;
  localparam int unsigned GapCyclesDefault     = 12;
  localparam int unsigned TimeoutCyclesDefault = 1024;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StLaunch    = 3'd1;
  localparam logic [2:0] StHandshake = 3'd2;
  localparam logic [2:0] StRelease   = 3'd3;
  localparam logic [2:0] StGap       = 3'd4;

endpackage

// File: rtl/ftdi_rr_arbiter.sv
// Round-robin arbiter: searches from last grant + 1; pointer moves only when en_i accepts a grant.
module ftdi_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IdxW'(NUM_REQ - 1);
    end else if (en_i && valid_o) begin
      ptr_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/ftdi_tx_scheduler.sv
// Multi-requester byte scheduler for the FTDI TX data_rdy/me_rdy interlock.
// Define FTDI_TX_SCHED_TIMEOUT_EN to enable the handshake watchdog.
module ftdi_tx_scheduler
  import ftdi_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NumReqDefault,
  parameter int unsigned MAX_BURST      = MaxBurstDefault,
  parameter int unsigned GAP_CYCLES     = GapCyclesDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  input  logic [NUM_REQ-1:0]     in_req_valid,
  input  logic [8*NUM_REQ-1:0]   in_req_data,
  input  logic [NUM_REQ-1:0]     in_req_last,
  output logic [NUM_REQ-1:0]     out_req_ack,
  output logic                   out_ftdi_tx_data_rdy,
  input  logic                   in_ftdi_tx_me_rdy,
  output logic [7:0]             out_ftdi_data,
  input  logic                   in_rx_enable,
  output logic                   out_ftdi_rx_ena,
  output logic                   out_busy,
  output logic                   out_timeout
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [2:0]         state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               lock_q, lock_d;
  logic               rdy_q, rdy_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         burst_q, burst_d;
  logic [7:0]         gap_q, gap_d;

  logic [NUM_REQ-1:0] arb_req, arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_valid, arb_en;

`ifdef FTDI_TX_SCHED_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  // While locked only the owning requester may win.
  assign arb_req = lock_q ? (in_req_valid & grant_q) : in_req_valid;
  assign arb_en  = (state_q == StIdle);

  ftdi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i     (in_clk),
    .rst_ni    (in_rst_n),
    .req_i     (arb_req),
    .en_i      (arb_en),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    lock_d  = lock_q;
    rdy_d   = rdy_q;
    grant_d = grant_q;
    ack_d   = '0;
    burst_d = burst_q;
    gap_d   = gap_q;
`ifdef FTDI_TX_SCHED_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          data_d  = in_req_data[{arb_idx, 3'b000} +: 8];
          last_d  = in_req_last[arb_idx];
          grant_d = arb_gnt;
          rdy_d   = 1'b1;
          state_d = StLaunch;
          if (!lock_q) begin
            lock_d  = 1'b1;
            burst_d = '0;
          end
        end
      end
      StLaunch: begin
        state_d = StHandshake;
`ifdef FTDI_TX_SCHED_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      StHandshake: begin
        if (in_ftdi_tx_me_rdy) begin
          state_d = StRelease;
          rdy_d   = 1'b0;
          ack_d   = grant_q;
          // End of packet or burst budget spent: hand the bus back to round-robin.
          if (last_q || (burst_q == 8'(MAX_BURST - 1))) begin
            lock_d  = 1'b0;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end
`ifdef FTDI_TX_SCHED_TIMEOUT_EN
        else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StGap;
          rdy_d     = 1'b0;
          lock_d    = 1'b0;
          burst_d   = '0;
          gap_d     = '0;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      StRelease: begin
        if (!in_ftdi_tx_me_rdy) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      last_q  <= 1'b0;
      lock_q  <= 1'b0;
      rdy_q   <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      burst_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      rdy_q   <= rdy_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

`ifdef FTDI_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_timeout = timeout_q;
`else
  // Watchdog compiled out; TIMEOUT_CYCLES only matters in the enabled build.
  assign out_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  assign out_req_ack          = ack_q;
  assign out_ftdi_tx_data_rdy = rdy_q;
  assign out_ftdi_data        = data_q;
  assign out_busy             = (state_q != StIdle) || lock_q;
  assign out_ftdi_rx_ena      = in_rx_enable &&
                                !((state_q == StLaunch) || (state_q == StHandshake));

endmodule

// File: tb/tb_ftdi_tx_scheduler.sv
// Scoreboard bench for ftdi_tx_scheduler: requester queues feed the DUT, an FTDI responder
// answers data_rdy, and every ack is matched against the expected (requester, byte) order.
module tb_ftdi_tx_scheduler;

  localparam int unsigned NUM_REQ        = 4;
  localparam int unsigned MAX_BURST      = 4;
  localparam int unsigned GAP_CYCLES     = 3;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic                 in_clk;
  logic                 in_rst_n;
  logic [NUM_REQ-1:0]   in_req_valid;
  logic [8*NUM_REQ-1:0] in_req_data;
  logic [NUM_REQ-1:0]   in_req_last;
  logic [NUM_REQ-1:0]   out_req_ack;
  logic                 out_ftdi_tx_data_rdy;
  logic                 in_ftdi_tx_me_rdy;
  logic [7:0]           out_ftdi_data;
  logic                 in_rx_enable;
  logic                 out_ftdi_rx_ena;
  logic                 out_busy;
  logic                 out_timeout;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [8:0] src_q [NUM_REQ][$];
  bit   resp_en = 1'b1;
  int   launch_cnt = 0;
  int   to_pulses = 0;

  ftdi_tx_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .MAX_BURST      (MAX_BURST),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .in_clk               (in_clk),
    .in_rst_n             (in_rst_n),
    .in_req_valid         (in_req_valid),
    .in_req_data          (in_req_data),
    .in_req_last          (in_req_last),
    .out_req_ack          (out_req_ack),
    .out_ftdi_tx_data_rdy (out_ftdi_tx_data_rdy),
    .in_ftdi_tx_me_rdy    (in_ftdi_tx_me_rdy),
    .out_ftdi_data        (out_ftdi_data),
    .in_rx_enable         (in_rx_enable),
    .out_ftdi_rx_ena      (out_ftdi_rx_ena),
    .out_busy             (out_busy),
    .out_timeout          (out_timeout)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  // Requester model: each requester presents the head of its queue, pops on ack.
  initial begin
    in_req_valid = '0;
    in_req_data  = '0;
    in_req_last  = '0;
    forever begin
      @(negedge in_clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (out_req_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          in_req_valid[i]       = 1'b1;
          in_req_data[i*8 +: 8] = src_q[i][0][7:0];
          in_req_last[i]        = src_q[i][0][8];
        end else begin
          in_req_valid[i] = 1'b0;
          in_req_last[i]  = 1'b0;
        end
      end
    end
  end

  // FTDI responder: raise me_rdy two cycles after data_rdy, drop it once data_rdy falls.
  initial begin
    int cnt;
    cnt = 0;
    in_ftdi_tx_me_rdy = 1'b0;
    forever begin
      @(negedge in_clk);
      if (!resp_en) begin
        in_ftdi_tx_me_rdy = 1'b0;
        cnt = 0;
      end else if (out_ftdi_tx_data_rdy && !in_ftdi_tx_me_rdy) begin
        cnt++;
        if (cnt >= 2) in_ftdi_tx_me_rdy = 1'b1;
      end else if (!out_ftdi_tx_data_rdy && in_ftdi_tx_me_rdy) begin
        in_ftdi_tx_me_rdy = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ack, checks launch spacing and data hold.
  initial begin
    bit                 rdy_prev, launch;
    logic [NUM_REQ-1:0] ack_prev, exp_oh;
    logic [7:0]         data_prev;
    int                 cyc, prev_launch;
    exp_t               e;
    rdy_prev = 0; ack_prev = '0; data_prev = '0; cyc = 0; prev_launch = -1;
    forever begin
      @(negedge in_clk);
      cyc++;
      if (!in_rst_n) begin
        rdy_prev = 0; ack_prev = '0; data_prev = out_ftdi_data; prev_launch = -1;
      end else begin
        launch = out_ftdi_tx_data_rdy && !rdy_prev;
        if (launch) begin
          launch_cnt++;
          if (prev_launch >= 0) begin
            checks++;
            if (cyc - prev_launch < int'(GAP_CYCLES) + 4) begin
              errors++;
              $display("FAIL launch_spacing: got %0d cycles, required >= %0d",
                       cyc - prev_launch, GAP_CYCLES + 4);
            end
          end
          prev_launch = cyc;
        end
        checks++;
        if (!launch && out_ftdi_data !== data_prev) begin
          errors++;
          $display("FAIL data_hold: got %02h, required %02h", out_ftdi_data, data_prev);
        end
        if (out_timeout === 1'b1) to_pulses++;
        if (out_req_ack !== '0) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got ack %b data %02h, required no ack",
                     out_req_ack, out_ftdi_data);
          end else begin
            e = sb.pop_front();
            exp_oh = '0;
            exp_oh[e.idx] = 1'b1;
            if (out_req_ack !== exp_oh || out_ftdi_data !== e.data) begin
              errors++;
              $display("FAIL ack_order: got ack %b data %02h, required ack %b data %02h",
                       out_req_ack, out_ftdi_data, exp_oh, e.data);
            end
          end
          checks++;
          if (ack_prev !== '0 || out_ftdi_tx_data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: got prev ack %b rdy %b, required 0 and 0",
                     ack_prev, out_ftdi_tx_data_rdy);
          end
        end
        rdy_prev  = out_ftdi_tx_data_rdy;
        ack_prev  = out_req_ack;
        data_prev = out_ftdi_data;
      end
    end
  end

  task automatic push_src(input int idx, input logic [7:0] data, input logic last);
    src_q[idx].push_back({last, data});
  endtask

  task automatic sb_push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  function automatic int src_total();
    int n;
    n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge in_clk);
      if (sb.size() == 0 && src_total() == 0 && out_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge in_clk);
      if (out_ftdi_tx_data_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    in_rst_n     = 1'b0;
    in_rx_enable = 1'b1;
    repeat (3) @(negedge in_clk);
    checks++;
    if (out_ftdi_tx_data_rdy !== 1'b0 || out_ftdi_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: got rdy %b data %02h, required 0 00",
               out_ftdi_tx_data_rdy, out_ftdi_data);
    end
    checks++;
    if (out_req_ack !== '0 || out_busy !== 1'b0 || out_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: got ack %b busy %b timeout %b, required 0 0 0",
               out_req_ack, out_busy, out_timeout);
    end
    checks++;
    if (out_ftdi_rx_ena !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ena_hi: got %b, required 1", out_ftdi_rx_ena);
    end
    in_rx_enable = 1'b0;
    #1;
    checks++;
    if (out_ftdi_rx_ena !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx_ena_lo: got %b, required 0", out_ftdi_rx_ena);
    end
    in_rx_enable = 1'b1;
    @(negedge in_clk);
    #1 in_rst_n = 1'b1;
  endtask

  task automatic test_two_requesters();
    bit ok;
    push_src(0, 8'hA5, 1'b1);
    push_src(2, 8'h3C, 1'b1);
    sb_push(0, 8'hA5);
    sb_push(2, 8'h3C);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL two_req_done: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_lock_packet();
    bit ok;
    int l0;
    push_src(1, 8'h11, 1'b0);
    push_src(1, 8'h12, 1'b0);
    sb_push(1, 8'h11);
    sb_push(1, 8'h12);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge in_clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lock_first_bytes: got %0d pending, required 0", sb.size());
    end
    // Requester 1 has dropped valid mid-packet; requester 3 must stay blocked.
    push_src(3, 8'h77, 1'b1);
    l0 = launch_cnt;
    repeat (12) @(negedge in_clk);
    checks++;
    if (launch_cnt != l0) begin
      errors++;
      $display("FAIL lock_hold: got %0d launches, required 0", launch_cnt - l0);
    end
    checks++;
    if (out_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_locked: got %b, required 1", out_busy);
    end
    push_src(1, 8'h13, 1'b1);
    sb_push(1, 8'h13);
    sb_push(3, 8'h77);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lock_done: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    for (int k = 0; k < 10; k++) push_src(0, 8'hB0 + 8'(k), k == 9);
    push_src(1, 8'hC1, 1'b1);
    for (int k = 0; k < 4; k++) sb_push(0, 8'hB0 + 8'(k));
    sb_push(1, 8'hC1);
    for (int k = 4; k < 10; k++) sb_push(0, 8'hB0 + 8'(k));
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL burst_done: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_rx_enable();
    bit ok;
    bit seen;
    in_rx_enable = 1'b1;
    push_src(2, 8'h99, 1'b1);
    sb_push(2, 8'h99);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge in_clk);
      if (out_ftdi_tx_data_rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (out_ftdi_rx_ena !== 1'b1) begin
        errors++;
        $display("FAIL rx_ena_pre: got %b, required 1", out_ftdi_rx_ena);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rx_launch: got no data_rdy, required launch");
    end
    checks++;
    if (out_ftdi_rx_ena !== 1'b0) begin
      errors++;
      $display("FAIL rx_ena_launch: got %b, required 0", out_ftdi_rx_ena);
    end
    @(negedge in_clk);
    checks++;
    if (out_ftdi_rx_ena !== 1'b0 || out_ftdi_tx_data_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rx_ena_handshake: got rx %b rdy %b, required 0 1",
               out_ftdi_rx_ena, out_ftdi_tx_data_rdy);
    end
    @(negedge in_clk);
    checks++;
    if (out_ftdi_rx_ena !== 1'b1) begin
      errors++;
      $display("FAIL rx_ena_release: got %b, required 1", out_ftdi_rx_ena);
    end
    in_rx_enable = 1'b0;
    #1;
    checks++;
    if (out_ftdi_rx_ena !== 1'b0) begin
      errors++;
      $display("FAIL rx_ena_off: got %b, required 0", out_ftdi_rx_ena);
    end
    in_rx_enable = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_done: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_handshake();
    bit ok;
    resp_en = 1'b0;
    push_src(0, 8'h5A, 1'b1);
    wait_rdy(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_hs_launch: got no data_rdy, required launch");
    end
    repeat (3) @(negedge in_clk);
    #1 in_rst_n = 1'b0;
    #1;
    checks++;
    if (out_ftdi_tx_data_rdy !== 1'b0 || out_ftdi_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_hs_tx: got rdy %b data %02h, required 0 00",
               out_ftdi_tx_data_rdy, out_ftdi_data);
    end
    checks++;
    if (out_req_ack !== '0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs_ctl: got ack %b busy %b, required 0 0", out_req_ack, out_busy);
    end
    // Requester 0 still holds its undelivered byte; requester 1 competes on release.
    push_src(1, 8'h01, 1'b1);
    sb_push(0, 8'h5A);
    sb_push(1, 8'h01);
    repeat (2) @(negedge in_clk);
    #1 in_rst_n = 1'b1;
    resp_en = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_hs_done: got %0d pending, required 0", sb.size());
    end
  endtask

`ifdef FTDI_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n, p0;
    resp_en = 1'b0;
    push_src(0, 8'hEE, 1'b1);
    push_src(1, 8'h42, 1'b1);
    sb_push(1, 8'h42);
    sb_push(0, 8'hEE);
    p0 = to_pulses;
    wait_rdy(ok);
    n = 0;
    while (ok && out_ftdi_tx_data_rdy === 1'b1 && n < 100) begin
      n++;
      @(negedge in_clk);
    end
    repeat (2) @(negedge in_clk);
    checks++;
    if (n != int'(TIMEOUT_CYCLES) + 1) begin
      errors++;
      $display("FAIL timeout_len: got %0d rdy cycles, required %0d", n, TIMEOUT_CYCLES + 1);
    end
    checks++;
    if (to_pulses - p0 != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses, required 1", to_pulses - p0);
    end
    resp_en = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_done: got %0d pending, required 0", sb.size());
    end
  endtask
`endif

  initial begin
    int exp_launches;
    in_rst_n     = 1'b0;
    in_rx_enable = 1'b1;
    exp_launches = 21;
    test_reset();
    test_two_requesters();
    test_lock_packet();
    test_max_burst();
    test_rx_enable();
    test_reset_handshake();
`ifdef FTDI_TX_SCHED_TIMEOUT_EN
    test_timeout();
    exp_launches = 24;
`else
    checks++;
    if (to_pulses != 0) begin
      errors++;
      $display("FAIL timeout_tied: got %0d pulses, required 0", to_pulses);
    end
`endif
    checks++;
    if (launch_cnt != exp_launches) begin
      errors++;
      $display("FAIL launch_total: got %0d, required %0d", launch_cnt, exp_launches);
    end
    checks++;
    if (sb.size() != 0 || src_total() != 0) begin
      errors++;
      $display("FAIL drained: got %0d/%0d pending, required 0/0", sb.size(), src_total());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
